// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: the execute->mem Signals bundle,
// memory access types, branch conditions and the stage FSM states.
package mem_stage_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned BE_W  = XLEN / 8;

  typedef enum logic [2:0] {
    LoadByte  = 3'd0,
    LoadHalf  = 3'd1,
    LoadWord  = 3'd2,
    LoadByteU = 3'd3,
    LoadHalfU = 3'd4
  } mem_type_e;

  typedef enum logic [2:0] {
    Never    = 3'd0,
    Always   = 3'd1,
    Zero     = 3'd2,
    NotZero  = 3'd3,
    Carry    = 3'd4,
    NotCarry = 3'd5
  } cond_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic zero;
    logic carry;
  } flags_t;

  typedef struct packed {
    logic [XLEN-1:0]  wdata;
    logic [XLEN-1:0]  reg2;
    logic             memr;
    logic             memw;
    mem_type_e        memt;
    logic             wback;
    logic [REG_W-1:0] wreg;
    cond_e            cond;
    flags_t           flags;
    logic [XLEN-1:0]  branch;
  } signals_t;

  // Resolve a conditional control transfer against the ALU flags.
  function automatic logic cond_taken(input cond_e c, input flags_t f);
    logic taken;
    taken = 1'b0;
    case (c)
      Always:   taken = 1'b1;
      Zero:     taken = f.zero;
      NotZero:  taken = !f.zero;
      Carry:    taken = f.carry;
      NotCarry: taken = !f.carry;
      default:  taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/mem_lane.sv
// Byte-lane steering for data memory: store enables/replication,
// load extraction with sign/zero extension, and alignment checking.
module mem_lane
  import mem_stage_pkg::*;
(
  input  mem_type_e       memt_i,
  input  logic [1:0]      off_i,
  input  logic [XLEN-1:0] reg2_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [BE_W-1:0] be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] load_ext_o,
  output logic            misaligned_o
);

  logic            is_byte;
  logic            is_half;
  logic            is_signed;
  logic [XLEN-1:0] shifted;

  always_comb begin
    is_byte   = 1'b0;
    is_half   = 1'b0;
    is_signed = 1'b0;
    case (memt_i)
      LoadByte:  begin is_byte = 1'b1; is_signed = 1'b1; end
      LoadByteU: is_byte = 1'b1;
      LoadHalf:  begin is_half = 1'b1; is_signed = 1'b1; end
      LoadHalfU: is_half = 1'b1;
      default:   ;
    endcase
  end

  // Bring the addressed byte/half down to bit 0.
  assign shifted = rdata_i >> {off_i, 3'b000};

  always_comb begin
    be_o         = {BE_W{1'b1}};
    wdata_o      = reg2_i;
    load_ext_o   = rdata_i;
    misaligned_o = |off_i;
    if (is_byte) begin
      be_o         = BE_W'(1) << off_i;
      wdata_o      = {BE_W{reg2_i[7:0]}};
      load_ext_o   = {{(XLEN-8){is_signed & shifted[7]}}, shifted[7:0]};
      misaligned_o = 1'b0;
    end else if (is_half) begin
      be_o         = BE_W'(3) << off_i;
      wdata_o      = {(BE_W/2){reg2_i[15:0]}};
      load_ext_o   = {{(XLEN-16){is_signed & shifted[15]}}, shifted[15:0]};
      misaligned_o = off_i[0];
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues loads/stores on a req/ack bus, extends load
// data, resolves conditional redirects and back-pressures execute while busy.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  signals_t        i_signals,
  input  logic            i_valid,
  output logic            stall,
  output signals_t        o_signals,
  output logic            o_valid,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            o_fault,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [BE_W-1:0] dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata
);

  localparam int unsigned CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;

  mem_state_e      state_q, state_d;
  signals_t        bundle_q, bundle_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  signals_t        o_signals_q, o_signals_d;
  logic            o_valid_q, o_valid_d;
  logic            o_fault_q, o_fault_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [BE_W-1:0] be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  signals_t        sel;
  logic [BE_W-1:0] lane_be;
  logic [XLEN-1:0] lane_wdata;
  logic [XLEN-1:0] lane_load;
  logic            lane_mis;
  logic            mem_go;
  logic            timeout_hit;
  signals_t        done;
  logic            done_v;
  logic            done_fault;

  // Lane logic looks at the incoming bundle when idle, the latched one when waiting.
  assign sel = (state_q == WAIT) ? bundle_q : i_signals;

  mem_lane u_lane (
    .memt_i      (sel.memt),
    .off_i       (sel.wdata[1:0]),
    .reg2_i      (sel.reg2),
    .rdata_i     (dmem_rdata),
    .be_o        (lane_be),
    .wdata_o     (lane_wdata),
    .load_ext_o  (lane_load),
    .misaligned_o(lane_mis)
  );

  assign mem_go      = (sel.memr ^ sel.memw) & !lane_mis;
  assign timeout_hit = (state_q == WAIT) && !dmem_ack && (BUS_TIMEOUT != 0)
                       && (cnt_q == CNT_W'(BUS_TIMEOUT - 1));

  // A timed-out access retires with a fault, so upstream is released too.
  assign stall = (state_q == WAIT) ? !(dmem_ack | timeout_hit) : (i_valid & mem_go);

  always_comb begin
    state_d          = state_q;
    bundle_d         = bundle_q;
    cnt_d            = cnt_q;
    req_d            = req_q;
    we_d             = we_q;
    addr_d           = addr_q;
    be_d             = be_q;
    wdata_d          = wdata_q;
    o_signals_d      = o_signals_q;
    o_valid_d        = 1'b0;
    o_fault_d        = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    done             = sel;
    done_v           = 1'b0;
    done_fault       = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          if (!(i_signals.memr | i_signals.memw)) begin
            done_v = 1'b1;
          end else if ((i_signals.memr & i_signals.memw) | lane_mis) begin
            done_v     = 1'b1;
            done_fault = 1'b1;
            done.wback = 1'b0;
          end else begin
            state_d  = WAIT;
            bundle_d = i_signals;
            cnt_d    = '0;
            req_d    = 1'b1;
            we_d     = i_signals.memw;
            addr_d   = {i_signals.wdata[XLEN-1:2], 2'b00};
            be_d     = i_signals.memw ? lane_be : '0;
            wdata_d  = lane_wdata;
          end
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          done_v  = 1'b1;
          if (bundle_q.memr) done.wdata = lane_load;
          if (bundle_q.memw) done.wback = 1'b0;
        end else if (timeout_hit) begin
          state_d    = IDLE;
          req_d      = 1'b0;
          done_v     = 1'b1;
          done_fault = 1'b1;
          done.wback = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Retire: one o_valid pulse carrying the result and any redirect.
    if (done_v) begin
      o_valid_d        = 1'b1;
      o_signals_d      = done;
      o_fault_d        = done_fault;
      redirect_valid_d = cond_taken(done.cond, done.flags);
      if (redirect_valid_d) redirect_pc_d = done.branch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      bundle_q         <= '0;
      cnt_q            <= '0;
      req_q            <= 1'b0;
      we_q             <= 1'b0;
      addr_q           <= '0;
      be_q             <= '0;
      wdata_q          <= '0;
      o_signals_q      <= '0;
      o_valid_q        <= 1'b0;
      o_fault_q        <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      bundle_q         <= bundle_d;
      cnt_q            <= cnt_d;
      req_q            <= req_d;
      we_q             <= we_d;
      addr_q           <= addr_d;
      be_q             <= be_d;
      wdata_q          <= wdata_d;
      o_signals_q      <= o_signals_d;
      o_valid_q        <= o_valid_d;
      o_fault_q        <= o_fault_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign o_signals      = o_signals_q;
  assign o_valid        = o_valid_q;
  assign o_fault        = o_fault_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign dmem_req       = req_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_be        = be_q;
  assign dmem_wdata     = wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads/stores, faults,
// redirects, bus timeout and reset during an outstanding access.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk;
  logic        rst_n;
  signals_t    i_signals;
  logic        i_valid;
  logic        stall;
  signals_t    o_signals;
  logic        o_valid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        o_fault;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  int n_chk = 0;
  int n_err = 0;

  mem_stage #(.BUS_TIMEOUT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_signals     (i_signals),
    .i_valid       (i_valid),
    .stall         (stall),
    .o_signals     (o_signals),
    .o_valid       (o_valid),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .o_fault       (o_fault),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_be       (dmem_be),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic signals_t mk(input logic [31:0] wdata, input logic [31:0] reg2,
                                  input logic memr, input logic memw, input mem_type_e memt,
                                  input logic wback, input cond_e cond,
                                  input logic zero, input logic carry, input logic [31:0] branch);
    signals_t s;
    s             = '0;
    s.wdata       = wdata;
    s.reg2        = reg2;
    s.memr        = memr;
    s.memw        = memw;
    s.memt        = memt;
    s.wback       = wback;
    s.wreg        = 5'd3;
    s.cond        = cond;
    s.flags.zero  = zero;
    s.flags.carry = carry;
    s.branch      = branch;
    return s;
  endfunction

  // Issue one legal access, ack it after wait_cyc extra WAIT cycles.
  task automatic run_mem(input string tag, input signals_t s, input int wait_cyc,
                         input logic [31:0] rdata, input logic [31:0] e_addr,
                         input logic [3:0] e_be, input logic [31:0] e_wdata,
                         input logic [31:0] e_out, input logic e_wback);
    i_signals = s;
    i_valid   = 1'b1;
    #1;
    check({tag, "_stall_acc"}, 32'(stall), 32'd1);
    tick();
    check({tag, "_req"}, 32'(dmem_req), 32'd1);
    check({tag, "_we"}, 32'(dmem_we), 32'(s.memw));
    check({tag, "_addr"}, dmem_addr, e_addr);
    check({tag, "_be"}, 32'(dmem_be), 32'(e_be));
    check({tag, "_wdata"}, dmem_wdata, e_wdata);
    check({tag, "_novalid"}, 32'(o_valid), 32'd0);
    for (int k = 0; k < wait_cyc; k++) begin
      check({tag, "_stall_wait"}, 32'(stall), 32'd1);
      tick();
      check({tag, "_req_hold"}, 32'(dmem_req), 32'd1);
      check({tag, "_addr_hold"}, dmem_addr, e_addr);
    end
    dmem_ack   = 1'b1;
    dmem_rdata = rdata;
    #1;
    check({tag, "_stall_ack"}, 32'(stall), 32'd0);
    tick();
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    i_valid    = 1'b0;
    check({tag, "_ovalid"}, 32'(o_valid), 32'd1);
    check({tag, "_fault"}, 32'(o_fault), 32'd0);
    check({tag, "_req_drop"}, 32'(dmem_req), 32'd0);
    check({tag, "_out"}, o_signals.wdata, e_out);
    check({tag, "_wback"}, 32'(o_signals.wback), 32'(e_wback));
    tick();
    check({tag, "_pulse"}, 32'(o_valid), 32'd0);
  endtask

  task automatic fault_case(input string tag, input signals_t s);
    i_signals = s;
    i_valid   = 1'b1;
    #1;
    check({tag, "_stall"}, 32'(stall), 32'd0);
    tick();
    i_valid = 1'b0;
    check({tag, "_noreq"}, 32'(dmem_req), 32'd0);
    check({tag, "_ovalid"}, 32'(o_valid), 32'd1);
    check({tag, "_fault"}, 32'(o_fault), 32'd1);
    check({tag, "_wback"}, 32'(o_signals.wback), 32'd0);
    tick();
    check({tag, "_fault_pulse"}, 32'(o_fault), 32'd0);
    check({tag, "_noreq2"}, 32'(dmem_req), 32'd0);
  endtask

  task automatic br_case(input string tag, input signals_t s, input logic e_taken,
                         input logic [31:0] e_pc);
    i_signals = s;
    i_valid   = 1'b1;
    tick();
    check({tag, "_ovalid"}, 32'(o_valid), 32'd1);
    check({tag, "_redir"}, 32'(redirect_valid), 32'(e_taken));
    if (e_taken) check({tag, "_pc"}, redirect_pc, e_pc);
  endtask

  initial begin
    rst_n      = 1'b0;
    i_valid    = 1'b0;
    i_signals  = '0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    #3;
    check("rst_ovalid", 32'(o_valid), 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_fault", 32'(o_fault), 32'd0);
    check("rst_redir", 32'(redirect_valid), 32'd0);
    check("rst_wback", 32'(o_signals.wback), 32'd0);
    check("rst_memr", 32'(o_signals.memr), 32'd0);
    check("rst_memw", 32'(o_signals.memw), 32'd0);
    check("rst_cond", 32'(o_signals.cond), 32'(Never));
    check("rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back non-memory ops: one result per cycle, no stall.
    i_signals = mk(32'h0000_1234, 32'h0, 1'b0, 1'b0, LoadByte, 1'b1, Never, 1'b0, 1'b0, 32'h0);
    i_valid   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("alu_stall", 32'(stall), 32'd0);
      tick();
      check("alu_ovalid", 32'(o_valid), 32'd1);
      check("alu_wdata", o_signals.wdata, 32'h0000_1234);
      check("alu_wback", 32'(o_signals.wback), 32'd1);
    end
    i_valid = 1'b0;
    tick();
    check("alu_idle", 32'(o_valid), 32'd0);

    run_mem("lb", mk(32'h0000_1003, 32'h0, 1'b1, 1'b0, LoadByte, 1'b1, Never, 1'b0, 1'b0, 32'h0),
            1, 32'h80FF_0000, 32'h0000_1000, 4'b0000, 32'h0, 32'hFFFF_FF80, 1'b1);
    run_mem("sh", mk(32'h0000_2002, 32'h0000_ABCD, 1'b0, 1'b1, LoadHalf, 1'b1, Never, 1'b0, 1'b0, 32'h0),
            0, 32'h0, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'h0000_2002, 1'b0);
    run_mem("lhu", mk(32'h0000_5002, 32'h0, 1'b1, 1'b0, LoadHalfU, 1'b1, Never, 1'b0, 1'b0, 32'h0),
            0, 32'h8001_1234, 32'h0000_5000, 4'b0000, 32'h0, 32'h0000_8001, 1'b1);
    run_mem("lh", mk(32'h0000_5002, 32'h0, 1'b1, 1'b0, LoadHalf, 1'b1, Never, 1'b0, 1'b0, 32'h0),
            0, 32'h8001_1234, 32'h0000_5000, 4'b0000, 32'h0, 32'hFFFF_8001, 1'b1);
    run_mem("sb", mk(32'h0000_6001, 32'h0000_005A, 1'b0, 1'b1, LoadByteU, 1'b1, Never, 1'b0, 1'b0, 32'h0),
            0, 32'h0, 32'h0000_6000, 4'b0010, 32'h5A5A_5A5A, 32'h0000_6001, 1'b0);
    run_mem("lw", mk(32'h0000_7004, 32'h0, 1'b1, 1'b0, LoadWord, 1'b1, Never, 1'b0, 1'b0, 32'h0),
            2, 32'hDEAD_BEEF, 32'h0000_7004, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1'b1);

    fault_case("mis_lw", mk(32'h0000_3001, 32'h0, 1'b1, 1'b0, LoadWord, 1'b1, Never, 1'b0, 1'b0, 32'h0));
    fault_case("mis_lh", mk(32'h0000_3003, 32'h0, 1'b1, 1'b0, LoadHalf, 1'b1, Never, 1'b0, 1'b0, 32'h0));
    fault_case("rw_both", mk(32'h0000_4000, 32'h0, 1'b1, 1'b1, LoadWord, 1'b1, Never, 1'b0, 1'b0, 32'h0));

    br_case("bnz_t", mk(32'h0, 32'h0, 1'b0, 1'b0, LoadByte, 1'b0, NotZero, 1'b0, 1'b0, 32'h400), 1'b1, 32'h400);
    br_case("bnz_n", mk(32'h0, 32'h0, 1'b0, 1'b0, LoadByte, 1'b0, NotZero, 1'b1, 1'b0, 32'h404), 1'b0, 32'h0);
    br_case("bz_t", mk(32'h0, 32'h0, 1'b0, 1'b0, LoadByte, 1'b0, Zero, 1'b1, 1'b0, 32'h500), 1'b1, 32'h500);
    br_case("bc_n", mk(32'h0, 32'h0, 1'b0, 1'b0, LoadByte, 1'b0, Carry, 1'b0, 1'b0, 32'h504), 1'b0, 32'h0);
    br_case("bnc_t", mk(32'h0, 32'h0, 1'b0, 1'b0, LoadByte, 1'b0, NotCarry, 1'b0, 1'b0, 32'h600), 1'b1, 32'h600);
    br_case("jmp_t", mk(32'h0, 32'h0, 1'b0, 1'b0, LoadByte, 1'b0, Always, 1'b1, 1'b1, 32'h700), 1'b1, 32'h700);
    br_case("nev_n", mk(32'h0, 32'h0, 1'b0, 1'b0, LoadByte, 1'b0, Never, 1'b1, 1'b1, 32'h800), 1'b0, 32'h0);
    i_valid = 1'b0;
    tick();
    check("br_pulse", 32'(redirect_valid), 32'd0);

    // Bus timeout after 4 WAIT cycles, then a late ack that must be ignored.
    i_signals = mk(32'h0000_8000, 32'h0, 1'b1, 1'b0, LoadWord, 1'b1, Never, 1'b0, 1'b0, 32'h0);
    i_valid   = 1'b1;
    tick();
    i_valid = 1'b0;
    check("to_req_w1", 32'(dmem_req), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("to_req_hold", 32'(dmem_req), 32'd1);
      check("to_novalid", 32'(o_valid), 32'd0);
    end
    tick();
    check("to_req_drop", 32'(dmem_req), 32'd0);
    check("to_ovalid", 32'(o_valid), 32'd1);
    check("to_fault", 32'(o_fault), 32'd1);
    check("to_wback", 32'(o_signals.wback), 32'd0);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    check("late_ack_valid", 32'(o_valid), 32'd0);
    check("late_ack_req", 32'(dmem_req), 32'd0);
    check("late_ack_fault", 32'(o_fault), 32'd0);

    // Reset while waiting abandons the access.
    i_signals = mk(32'h0000_9000, 32'h0, 1'b1, 1'b0, LoadWord, 1'b1, Never, 1'b0, 1'b0, 32'h0);
    i_valid   = 1'b1;
    tick();
    i_valid = 1'b0;
    check("rw_req_w1", 32'(dmem_req), 32'd1);
    tick();
    check("rw_req_w2", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rw_req_now", 32'(dmem_req), 32'd0);
    check("rw_ovalid_now", 32'(o_valid), 32'd0);
    tick();
    check("rw_ovalid_rst", 32'(o_valid), 32'd0);
    rst_n    = 1'b1;
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    check("rw_ovalid_after", 32'(o_valid), 32'd0);
    check("rw_req_after", 32'(dmem_req), 32'd0);
    check("rw_fault_after", 32'(o_fault), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
